// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture path: FSM state encoding and the
// default sample/address widths (address width matches the carrier generator).
package adc_capture_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    ARM     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/level_trigger_detect.sv
// ADC input register pair, rising level-crossing detector and the ARM-state
// timeout counter that forces a capture when no crossing arrives.
module level_trigger_detect #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] TRIG_LEVEL = DATA_W'(128),
  parameter int                TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_arm,
  output logic [DATA_W-1:0] o_prev_q,
  output logic              o_trig_hit,
  output logic              o_trig_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [DATA_W-1:0] r_sample_q;
  logic [DATA_W-1:0] r_prev_q;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_expired;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would turn prev_q into a copy of adc_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample_q <= '0;
      r_prev_q   <= '0;
    end else begin
      r_sample_q <= i_adc_data;
      r_prev_q   <= r_sample_q;
    end
  end

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Counter is held at zero outside ARM, so it restarts on every ARM entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_arm) begin
      r_cnt <= '0;
    end else if (!w_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_prev_q       = r_prev_q;
  assign o_trig_hit     = (r_prev_q < TRIG_LEVEL) && (r_sample_q >= TRIG_LEVEL);
  assign o_trig_timeout = i_arm && w_expired;

endmodule

// File: rtl/adc_capture_controller.sv
// ADC burst capture controller: flush the ADC pipeline, optionally wait for a
// rising level crossing, then write 2^ADDR_W consecutive samples to the RAM.
module adc_capture_controller
  import adc_capture_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                ADC_LATENCY = 5,
  parameter logic [DATA_W-1:0] TRIG_LEVEL  = DATA_W'(128),
  parameter int                TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  output logic              adc_oe_n,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int FL_W = (ADC_LATENCY > 0) ? $clog2(ADC_LATENCY + 1) : 1;

  cap_state_e        r_state;
  cap_state_e        w_state_next;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [FL_W-1:0]   w_flush_cnt_next;
  logic [ADDR_W-1:0] r_cap_cnt;
  logic [ADDR_W-1:0] w_cap_cnt_next;
  logic              r_trig_en;
  logic              w_trig_en_next;
  logic              r_timed_out;
  logic              w_timed_out_next;

  logic              w_arm;
  logic              w_trig_hit;
  logic              w_trig_timeout;
  logic [DATA_W-1:0] w_prev_q;

  logic              r_adc_oe_n;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;

  assign adc_clk = clk;
  assign w_arm   = (r_state == ARM);

  level_trigger_detect #(
    .DATA_W    (DATA_W),
    .TRIG_LEVEL(TRIG_LEVEL),
    .TIMEOUT   (TIMEOUT)
  ) u_trig (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_adc_data    (adc_data),
    .i_arm         (w_arm),
    .o_prev_q      (w_prev_q),
    .o_trig_hit    (w_trig_hit),
    .o_trig_timeout(w_trig_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_cap_cnt   <= '0;
      r_trig_en   <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_cap_cnt   <= w_cap_cnt_next;
      r_trig_en   <= w_trig_en_next;
      r_timed_out <= w_timed_out_next;
    end
  end

  // NOTE: every signal assigned below gets its default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_cap_cnt_next   = r_cap_cnt;
    w_trig_en_next   = r_trig_en;
    w_timed_out_next = r_timed_out;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_trig_en_next   = trig_en;
          w_timed_out_next = 1'b0;
          w_flush_cnt_next = FL_W'(ADC_LATENCY);
          w_state_next     = FLUSH;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_cap_cnt_next = '0;
          w_state_next   = r_trig_en ? ARM : CAPTURE;
        end else begin
          w_flush_cnt_next = r_flush_cnt - FL_W'(1);
        end
      end
      ARM: begin
        // A crossing on the expiry cycle is a genuine trigger, not a timeout.
        if (w_trig_hit) begin
          w_cap_cnt_next = '0;
          w_state_next   = CAPTURE;
        end else if (w_trig_timeout) begin
          w_cap_cnt_next   = '0;
          w_timed_out_next = 1'b1;
          w_state_next     = CAPTURE;
        end
      end
      CAPTURE: begin
        w_cap_cnt_next = r_cap_cnt + ADDR_W'(1);
        if (r_cap_cnt == '1) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output stage sits one register behind the FSM. The sample that was in
  // sample_q on the CAPTURE-entry edge is in prev_q one edge later, so writes
  // take prev_q and address 0 still holds the triggering sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adc_oe_n <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en    <= (r_state == CAPTURE);
      r_wr_addr  <= (r_state == CAPTURE) ? r_cap_cnt : '0;
      r_done     <= (r_state == DONE);
      r_busy     <= (w_state_next != IDLE) || (r_state == DONE);
      r_adc_oe_n <= (w_state_next == IDLE);
      if (r_state == CAPTURE) begin
        r_wr_data <= w_prev_q;
      end
    end
  end

  assign adc_oe_n  = r_adc_oe_n;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timed_out = r_timed_out;

endmodule

// File: tb/tb_adc_capture_controller.sv
// Directed self-checking bench for adc_capture_controller: free-run, level
// trigger, timeout, trigger-at-expiry, ignored starts and mid-burst reset.
module tb_adc_capture_controller;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 5;
  localparam int ADC_LATENCY = 5;
  localparam int TIMEOUT     = 1023;
  localparam int BURST       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              trig_en;
  logic [DATA_W-1:0] adc_data;
  logic              adc_clk;
  logic              adc_oe_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              timed_out;

  always #5 clk = ~clk;

  adc_capture_controller #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .ADC_LATENCY(ADC_LATENCY),
    .TRIG_LEVEL (8'd128),
    .TIMEOUT    (TIMEOUT)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .trig_en  (trig_en),
    .adc_data (adc_data),
    .adc_clk  (adc_clk),
    .adc_oe_n (adc_oe_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .timed_out(timed_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Write-port recorder, sampled 1 time unit after each rising edge.
  int                cyc            = 0;
  int                wr_total       = 0;
  int                done_total     = 0;
  int                rise_total     = 0;
  int                addr_err_total = 0;
  int                last_rise_cyc  = 0;
  int                last_done_cyc  = 0;
  int                run_idx        = 0;
  logic              busy_at_done   = 1'b0;
  logic              prev_wr_en     = 1'b0;
  logic [DATA_W-1:0] cap_data [BURST];

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      if (prev_wr_en !== 1'b1) begin
        rise_total    = rise_total + 1;
        run_idx       = 0;
        last_rise_cyc = cyc;
      end
      if (wr_addr !== ADDR_W'(run_idx)) addr_err_total = addr_err_total + 1;
      cap_data[wr_addr] = wr_data;
      run_idx  = run_idx + 1;
      wr_total = wr_total + 1;
    end
    if (done === 1'b1) begin
      done_total    = done_total + 1;
      last_done_cyc = cyc;
      busy_at_done  = busy;
    end
    prev_wr_en = wr_en;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  logic              ramp = 1'b0;
  logic [DATA_W-1:0] seq [5];
  int c0, n, b_wr, b_rise, b_done, b_aerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ramp) adc_data = adc_data + 8'd1;
  endtask

  // Leaves the caller at the falling edge right after the accepting edge 0.
  task automatic do_start(input logic te, output int c_start);
    tick();
    start   = 1'b1;
    trig_en = te;
    tick();
    start   = 1'b0;
    c_start = cyc;
  endtask

  task automatic snap();
    b_wr   = wr_total;
    b_rise = rise_total;
    b_done = done_total;
    b_aerr = addr_err_total;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done_total == b_done && k < budget) begin
      tick();
      k++;
    end
    check(tag, done_total - b_done, 1);
  endtask

  task automatic check_burst(input string tag);
    check({tag, "_writes"},    wr_total - b_wr, BURST);
    check({tag, "_contig"},    rise_total - b_rise, 1);
    check({tag, "_addr_seq"},  addr_err_total - b_aerr, 0);
    check({tag, "_done_once"}, done_total - b_done, 1);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    trig_en  = 1'b0;
    adc_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_oe_n", adc_oe_n, 1);
    check("rst_timed_out", timed_out, 0);
    #1 check("adc_clk_low", adc_clk, 0);
    @(posedge clk);
    #1 check("adc_clk_high", adc_clk, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", busy, 0);
    check("idle_oe_n", adc_oe_n, 1);

    // Free-running capture of a ramp: adc_data equals the edge number.
    snap();
    ramp     = 1'b1;
    adc_data = 8'hFF;
    do_start(1'b0, c0);
    check("t1_busy_after_start", busy, 1);
    check("t1_oe_n_after_start", adc_oe_n, 0);
    check("t1_no_write_yet", wr_en, 0);
    wait_done("t1_done_seen", 100);
    check("t1_first_write_latency", last_rise_cyc - c0, ADC_LATENCY + 2);
    check("t1_done_latency", last_done_cyc - c0, ADC_LATENCY + 2 + BURST);
    check_burst("t1");
    check("t1_data_addr0", cap_data[0], 5);
    check("t1_data_addr15", cap_data[15], 20);
    check("t1_data_addr31", cap_data[31], 36);
    check("t1_busy_with_done", busy_at_done, 1);
    check("t1_timed_out", timed_out, 0);
    tick();
    check("t1_busy_drops", busy, 0);
    check("t1_done_pulse_ends", done, 0);
    check("t1_oe_n_idle", adc_oe_n, 1);

    // Level trigger on 127 -> 128; trig_en dropped after acceptance.
    snap();
    ramp     = 1'b0;
    adc_data = 8'd100;
    do_start(1'b1, c0);
    trig_en = 1'b0;
    repeat (10) tick();
    check("t2_armed_no_write", wr_en, 0);
    check("t2_armed_busy", busy, 1);
    seq = '{8'd110, 8'd120, 8'd127, 8'd128, 8'd140};
    for (int i = 0; i < 5; i++) begin
      tick();
      adc_data = seq[i];
    end
    ramp = 1'b1;
    wait_done("t2_done_seen", 200);
    check_burst("t2");
    check("t2_data_addr0", cap_data[0], 128);
    check("t2_data_addr1", cap_data[1], 140);
    check("t2_data_addr2", cap_data[2], 141);
    check("t2_data_addr31", cap_data[31], 170);
    check("t2_timed_out", timed_out, 0);

    // Constant 200 never crosses: auto-trigger after TIMEOUT ARM cycles.
    snap();
    ramp     = 1'b0;
    adc_data = 8'd200;
    do_start(1'b1, c0);
    wait_done("t3_done_seen", 1200);
    check("t3_done_latency", last_done_cyc - c0, ADC_LATENCY + 2 + TIMEOUT + BURST);
    check_burst("t3");
    check("t3_timed_out", timed_out, 1);
    check("t3_data_addr0", cap_data[0], 200);
    check("t3_data_addr31", cap_data[31], 200);

    // Crossing lands exactly on the expiry cycle: trigger wins.
    snap();
    adc_data = 8'd100;
    do_start(1'b1, c0);
    check("t4_start_clears_timed_out", timed_out, 0);
    repeat (1027) tick();
    adc_data = 8'd150;
    wait_done("t4_done_seen", 200);
    check("t4_done_latency", last_done_cyc - c0, ADC_LATENCY + 2 + TIMEOUT + BURST);
    check_burst("t4");
    check("t4_timed_out", timed_out, 0);
    check("t4_data_addr0", cap_data[0], 150);

    // start pulses during CAPTURE and during DONE are ignored.
    snap();
    adc_data = 8'd55;
    do_start(1'b0, c0);
    repeat (14) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (23) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_done_at_39", done, 1);
    tick();
    check("t5_done_start_ignored", busy, 0);
    check("t5_done_dropped", done, 0);
    check_burst("t5");
    check("t5_data_addr0", cap_data[0], 55);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_busy", busy, 1);
    check("t5_restart_timed_out", timed_out, 0);

    // Asynchronous reset at write 12 of the restarted burst.
    b_wr = wr_total;
    n    = 0;
    while (wr_total - b_wr < 12 && n < 100) begin
      tick();
      n++;
    end
    check("t6_reached_write_12", wr_total - b_wr, 12);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_wr_en", wr_en, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_wr_addr", wr_addr, 0);
    check("t6_async_wr_data", wr_data, 0);
    check("t6_async_oe_n", adc_oe_n, 1);
    check("t6_async_done", done, 0);
    check("t6_async_timed_out", timed_out, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    snap();
    adc_data = 8'd77;
    do_start(1'b0, c0);
    wait_done("t6_done_seen", 100);
    check("t6_first_write_latency", last_rise_cyc - c0, ADC_LATENCY + 2);
    check_burst("t6");
    check("t6_data_addr0", cap_data[0], 77);
    check("t6_data_addr31", cap_data[31], 77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
